// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 matrix keypad by pulling one column low at a time (the other
// columns float), debounces a single pressed key, and hands its 4-bit code
// to the operand-entry logic on a valid/ready handshake.
//
// Optional feature macro: KEYPAD_AUTOREPEAT_EN
//   When defined, a key held down re-emits its code every REPEAT_SCANS
//   samples while in the HELD state. When undefined, HELD never emits.
//
// Parameters
//   SCAN_DIV        cycles each column is driven (>= 4)
//   DEBOUNCE_SCANS  consecutive identical samples to accept a press/release (>= 2)
//   REPEAT_SCANS    samples between auto-repeat codes (autorepeat builds only)
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   key_row      keypad rows, active-low, asynchronous to clk
//   key_col      column drives: one bit 0, the others high-impedance
//   key_code     {row_idx, col_idx} of the accepted key
//   key_valid    key_code is valid, held until accepted
//   key_ready    consumer accepts key_code when high together with key_valid
//   key_overrun  sticky: a code was dropped while key_valid was pending
// -----------------------------------------------------------------------------
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 8,
    parameter int REPEAT_SCANS   = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_overrun
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);

    if (SCAN_DIV < 4) begin : g_bad_scan_div
        $error("keypad_scanner: SCAN_DIV must be at least 4");
    end
    if (DEBOUNCE_SCANS < 2) begin : g_bad_debounce
        $error("keypad_scanner: DEBOUNCE_SCANS must be at least 2");
    end
    if (REPEAT_SCANS < 1) begin : g_bad_repeat
        $error("keypad_scanner: REPEAT_SCANS must be at least 1");
    end

    typedef enum logic [1:0] {
        ST_SCAN    = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_HELD    = 2'd2
    } state_t;

    logic [3:0]       row_meta_q;
    logic [3:0]       row_sync_q;
    logic             drive_en_q;
    logic [DIV_W-1:0] dwell_q,       dwell_d;
    logic [1:0]       col_idx_q,     col_idx_d;
    state_t           state_q,       state_d;
    logic [CNT_W-1:0] cnt_q,         cnt_d;
    logic [1:0]       cand_row_q,    cand_row_d;
    logic [3:0]       key_code_q,    key_code_d;
    logic             key_valid_q,   key_valid_d;
    logic             key_overrun_q, key_overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_W = $clog2(REPEAT_SCANS + 1);
    logic [REP_W-1:0] rep_q,         rep_d;
`endif

    logic       sample;
    logic       hit;
    logic [1:0] hit_row;
    logic       emit;

    // Column drive: open-drain style, only the selected column is pulled low.
    // Nothing is driven until the first clock after reset release.
    for (genvar i = 0; i < 4; i++) begin : g_col
        assign key_col[i] = (drive_en_q && (col_idx_q == 2'(i))) ? 1'b0 : 1'bz;
    end

    assign key_code    = key_code_q;
    assign key_valid   = key_valid_q;
    assign key_overrun = key_overrun_q;

    assign sample = drive_en_q && (dwell_q == DIV_W'(SCAN_DIV - 1));

    // Single-hit decode: exactly one row low. No row or several rows low
    // (ghosting from multiple keys) both read as "no key".
    always_comb begin
        hit     = 1'b0;
        hit_row = 2'd0;
        case (row_sync_q)
            4'b1110: begin hit = 1'b1; hit_row = 2'd0; end
            4'b1101: begin hit = 1'b1; hit_row = 2'd1; end
            4'b1011: begin hit = 1'b1; hit_row = 2'd2; end
            4'b0111: begin hit = 1'b1; hit_row = 2'd3; end
            default: begin hit = 1'b0; hit_row = 2'd0; end
        endcase
    end

    always_comb begin
        dwell_d       = dwell_q;
        col_idx_d     = col_idx_q;
        state_d       = state_q;
        cnt_d         = cnt_q;
        cand_row_d    = cand_row_q;
        key_code_d    = key_code_q;
        key_valid_d   = key_valid_q;
        key_overrun_d = key_overrun_q;
        emit          = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d         = rep_q;
`endif

        if (drive_en_q) begin
            dwell_d = sample ? '0 : dwell_q + 1'b1;
        end

        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (hit) begin
                        cand_row_d = hit_row;
                        cnt_d      = CNT_W'(1);
                        state_d    = ST_CONFIRM;
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_CONFIRM: begin
                    if (hit && (hit_row == cand_row_q)) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            emit    = 1'b1;
                            state_d = ST_HELD;
                            cnt_d   = '0;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        state_d   = ST_SCAN;
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_HELD: begin
                    // Release needs DEBOUNCE_SCANS all-high samples in a row;
                    // any low row (bounce) restarts the count.
                    if (row_sync_q == 4'hF) begin
                        if (cnt_q == CNT_W'(DEBOUNCE_SCANS - 1)) begin
                            state_d   = ST_SCAN;
                            col_idx_d = col_idx_q + 2'd1;
                            cnt_d     = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end else begin
                        cnt_d = '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    if (hit && (hit_row == cand_row_q)) begin
                        if (rep_q == REP_W'(REPEAT_SCANS - 1)) begin
                            emit  = 1'b1;
                            rep_d = '0;
                        end else begin
                            rep_d = rep_q + 1'b1;
                        end
                    end else begin
                        rep_d = '0;
                    end
`endif
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end

        // An emit in the same cycle as an accept replaces the accepted code.
        if (emit) begin
            if (!key_valid_q || key_ready) begin
                key_code_d  = {cand_row_q, col_idx_q};
                key_valid_d = 1'b1;
            end else begin
                key_overrun_d = 1'b1;
            end
        end else if (key_valid_q && key_ready) begin
            key_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_meta_q    <= 4'hF;
            row_sync_q    <= 4'hF;
            drive_en_q    <= 1'b0;
            dwell_q       <= '0;
            col_idx_q     <= 2'd0;
            state_q       <= ST_SCAN;
            cnt_q         <= '0;
            key_code_q    <= 4'd0;
            key_valid_q   <= 1'b0;
            key_overrun_q <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q         <= '0;
`endif
        end else begin
            row_meta_q    <= key_row;
            row_sync_q    <= row_meta_q;
            drive_en_q    <= 1'b1;
            dwell_q       <= dwell_d;
            col_idx_q     <= col_idx_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_code_q    <= key_code_d;
            key_valid_q   <= key_valid_d;
            key_overrun_q <= key_overrun_d;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_q         <= rep_d;
`endif
        end
    end

    // Candidate row is only read in CONFIRM/HELD, after SCAN has loaded it.
    always_ff @(posedge clk) begin
        cand_row_q <= cand_row_d;
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// -----------------------------------------------------------------------------
// tb_keypad_scanner
//
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=5.
// A keypad model pulls a row low only while the pressed key's column is
// driven low; column lines are pulled up so a floating column reads 1.
// -----------------------------------------------------------------------------
module tb_keypad_scanner;

    localparam int SCAN_DIV = 4;
    localparam int DEB      = 3;
    localparam int REP      = 5;
    localparam int LAT      = (4 + DEB - 1) * SCAN_DIV + 3;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_CODES = 3;
`else
    localparam int REP_CODES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_row;
    wire  [3:0] key_col_w;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_ready = 1'b1;
    logic       key_overrun;

    pullup (key_col_w[0]);
    pullup (key_col_w[1]);
    pullup (key_col_w[2]);
    pullup (key_col_w[3]);

    int checks   = 0;
    int failures = 0;

    logic       press_en  = 1'b0;
    logic [1:0] press_row = 2'd0;
    logic [1:0] press_col = 2'd0;
    logic       force_en  = 1'b0;
    logic [3:0] force_row = 4'hF;

    int         code_cnt = 0;
    logic [3:0] code_q[$];
    logic [3:0] exp_q[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_DIV      (SCAN_DIV),
        .DEBOUNCE_SCANS(DEB),
        .REPEAT_SCANS  (REP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_row    (key_row),
        .key_col    (key_col_w),
        .key_code   (key_code),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_overrun(key_overrun)
    );

    // Keypad matrix: the pressed switch connects its row to its column.
    always_comb begin
        key_row = 4'hF;
        if (force_en) begin
            key_row = force_row;
        end else if (press_en && (key_col_w[press_col] == 1'b0)) begin
            key_row[press_row] = 1'b0;
        end
    end

    // Record every accepted code (valid && ready seen at the accepting edge).
    always @(posedge clk) begin
        if (!rst && key_valid && key_ready) begin
            code_cnt <= code_cnt + 1;
            code_q.push_back(key_code);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_valid(input int bound, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < bound && !seen; i++) begin
            @(negedge clk);
            if (key_valid === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic press(input logic [1:0] r, input logic [1:0] c);
        press_row = r;
        press_col = c;
        press_en  = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit   seen;
        int   c0;
        int   nrand;
        logic [1:0] r, c;
        logic [3:0] exp_col;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_col",   key_col_w,   4'hF);
        chk("rst_valid", key_valid,   1'b0);
        chk("rst_code",  key_code,    4'h0);
        chk("rst_ovr",   key_overrun, 1'b0);
        rst = 1'b0;

        // Column walk, 4 cycles per column
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            exp_col = 4'hF;
            exp_col[((k - 1) / SCAN_DIV) % 4] = 1'b0;
            chk("scan_col", key_col_w, exp_col);
        end

        // Single press of key 6 (row 1, column 2)
        @(negedge clk);
        c0 = code_cnt;
        press(2'd1, 2'd2);
        wait_valid(LAT, seen);
        chk("press_lat",  seen,     1'b1);
        chk("press_code", key_code, 4'h6);
        repeat (8) @(negedge clk);
        chk("press_held_once", code_cnt - c0, 1);
        press_en = 1'b0;
        repeat (30) @(negedge clk);
        chk("press_once", code_cnt - c0, 1);

        // Random presses against a queue of expected codes
        code_q.delete();
        exp_q.delete();
        for (int n = 0; n < 12; n++) begin
            r = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            exp_q.push_back({r, c});
            repeat ($urandom_range(0, 7)) @(negedge clk);
            press(r, c);
            wait_valid(LAT, seen);
            chk("rand_lat", seen, 1'b1);
            repeat ($urandom_range(2, 14)) @(negedge clk);
            press_en = 1'b0;
            repeat ($urandom_range(20, 40)) @(negedge clk);
        end
        chk("rand_count", code_q.size(), exp_q.size());
        nrand = (code_q.size() < exp_q.size()) ? code_q.size() : exp_q.size();
        for (int i = 0; i < nrand; i++) begin
            chk("rand_code", code_q[i], exp_q[i]);
        end
        chk("rand_ovr", key_overrun, 1'b0);

        // Backpressure: second key is dropped and flagged
        key_ready = 1'b0;
        press(2'd1, 2'd2);
        wait_valid(LAT, seen);
        chk("bp_first", seen, 1'b1);
        repeat (8) @(negedge clk);
        press_en = 1'b0;
        repeat (24) @(negedge clk);
        press(2'd0, 2'd3);
        repeat (LAT + 3) @(negedge clk);
        press_en = 1'b0;
        repeat (24) @(negedge clk);
        chk("bp_valid", key_valid,   1'b1);
        chk("bp_code",  key_code,    4'h6);
        chk("bp_ovr",   key_overrun, 1'b1);
        key_ready = 1'b1;
        @(negedge clk);
        chk("bp_drop",   key_valid,   1'b0);
        chk("bp_sticky", key_overrun, 1'b1);

        // Bounce: row toggles every sample period
        c0 = code_cnt;
        force_en = 1'b1;
        for (int i = 0; i < 16; i++) begin
            force_row = i[0] ? 4'hF : 4'hD;
            repeat (SCAN_DIV) @(negedge clk);
        end
        force_row = 4'hF;
        repeat (12) @(negedge clk);
        chk("bounce_none", code_cnt - c0, 0);

        // Ghosting: two rows low
        force_row = 4'hC;
        repeat (60) @(negedge clk);
        force_en = 1'b0;
        force_row = 4'hF;
        repeat (20) @(negedge clk);
        chk("ghost_none", code_cnt - c0, 0);
        chk("ghost_valid", key_valid, 1'b0);

        // Reset after two matching samples in CONFIRM
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("mc_ovr_cleared", key_overrun, 1'b0);
        press(2'd1, 2'd2);
        rst = 1'b0;
        c0 = code_cnt;
        repeat (18) @(negedge clk);
        chk("mc_pre_valid", key_valid, 1'b0);
        rst = 1'b1;
        #1;
        chk("mc_col",   key_col_w, 4'hF);
        chk("mc_valid", key_valid, 1'b0);
        chk("mc_code",  key_code,  4'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        wait_valid(LAT, seen);
        chk("mc_redetect", seen, 1'b1);
        chk("mc_code6", key_code, 4'h6);
        repeat (8) @(negedge clk);
        press_en = 1'b0;
        repeat (24) @(negedge clk);
        chk("mc_once", code_cnt - c0, 1);

        // Long hold: auto-repeat codes only in autorepeat builds
        c0 = code_cnt;
        press(2'd1, 2'd2);
        wait_valid(LAT, seen);
        chk("rep_first", seen, 1'b1);
        repeat (12 * SCAN_DIV) @(negedge clk);
        press_en = 1'b0;
        repeat (24) @(negedge clk);
        chk("rep_count", code_cnt - c0, REP_CODES);
        chk("rep_last",  key_code, 4'h6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
